gctr_xor: RTL and testbench

GCTR_XOR -- requirements
Module: gctr_xor

---
 rtl/gcm_pkg.sv | 28 ++
 rtl/ks_fifo.sv | 66 ++++++
 rtl/gctr_xor.sv | 181 ++++++++++++++++++
 tb/tb_gctr_xor.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block/byte-count widths, the fetch FSM state type
// and the partial-block byte mask.
package gcm_pkg;

    localparam int BLOCK_W     = 128;
    localparam int BYTE_CNT_W  = 5;
    localparam int BLOCK_BYTES = BLOCK_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_CTR,
        ISSUE
    } fetch_state_e;

    // Byte 0 is the most significant byte; the first nbytes bytes are kept.
    function automatic logic [BLOCK_W-1:0] byte_mask(input logic [BYTE_CNT_W-1:0] nbytes);
        logic [BLOCK_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i < int'(nbytes)) begin
                mask[BLOCK_W-1-8*i -: 8] = 8'hFF;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ks_fifo.sv
// Synchronous keystream buffer with occupancy count and a single-cycle flush
// that takes priority over a simultaneous push/pop.
module ks_fifo
    import gcm_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; only count_q decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/gctr_xor.sv
// GCTR keystream XOR: fetches counter blocks, sends them through AES, buffers
// the keystream and XORs it with the data stream in a zero-cycle join.
module gctr_xor
    import gcm_pkg::*;
#(
    parameter int KS_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           nblocks,
    output logic                  ctr_next,
    input  logic [BLOCK_W-1:0]    ctr_block,
    input  logic                  ctr_valid,
    output logic                  aes_in_valid,
    input  logic                  aes_in_ready,
    output logic [BLOCK_W-1:0]    aes_in_block,
    input  logic                  aes_out_valid,
    output logic                  aes_out_ready,
    input  logic [BLOCK_W-1:0]    aes_out_block,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [BLOCK_W-1:0]    din_data,
    input  logic                  din_last,
    input  logic [BYTE_CNT_W-1:0] din_bytes,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [BLOCK_W-1:0]    dout_data,
    output logic                  dout_last,
    output logic [BYTE_CNT_W-1:0] dout_bytes,
    output logic                  busy,
    output logic                  done
);

    localparam int FIFO_CNT_W = $clog2(KS_DEPTH + 1);
    localparam int OCC_W      = 5;

    fetch_state_e state_q, state_d;
    logic [31:0]        remaining_q, remaining_d;
    logic [31:0]        out_left_q, out_left_d;
    logic [3:0]         inflight_q, inflight_d;
    logic [3:0]         discard_q, discard_d;
    logic [3:0]         inflight_live;
    logic [BLOCK_W-1:0] ctr_q, ctr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               live_q;

    logic [BLOCK_W-1:0]    ks_data;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full, fifo_empty;

    logic accept, room, issue_hs, ks_hs, ks_keep, ks_drop, out_hs, finish;

    assign accept  = start && !busy_q;
    assign room    = (OCC_W'(fifo_count) + OCC_W'(inflight_q)) < OCC_W'(KS_DEPTH);
    assign ks_hs   = aes_out_valid && aes_out_ready;
    assign ks_drop = ks_hs && (discard_q != '0);
    assign ks_keep = ks_hs && (discard_q == '0);
    assign out_hs  = dout_valid && dout_ready;
    // A message ends on its last counted block or on an early din_last.
    assign finish  = busy_q && out_hs && (din_last || (out_left_q == 32'd1));

    ks_fifo #(
        .DEPTH (KS_DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (finish),
        .push  (ks_keep),
        .pop   (out_hs),
        .wdata (aes_out_block),
        .rdata (ks_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        ctr_d        = ctr_q;
        ctr_next     = 1'b0;
        aes_in_valid = 1'b0;
        issue_hs     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (nblocks != '0)) begin
                    remaining_d = nblocks;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (room && !finish) begin
                    ctr_next = 1'b1;
                    state_d  = WAIT_CTR;
                end
            end
            WAIT_CTR: begin
                if (ctr_valid) begin
                    ctr_d   = ctr_block;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                aes_in_valid = 1'b1;
                if (aes_in_ready) begin
                    issue_hs    = 1'b1;
                    remaining_d = remaining_q - 32'd1;
                    state_d     = (remaining_q > 32'd1) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d     = IDLE;
            remaining_d = '0;
        end
    end

    // Keystream still inside AES at the end of a message is moved to the
    // discard count so it is dropped on return instead of being buffered.
    always_comb begin
        inflight_live = inflight_q + 4'(issue_hs) - 4'(ks_keep);
        inflight_d    = inflight_live;
        discard_d     = discard_q - 4'(ks_drop);
        out_left_d    = out_left_q;
        busy_d        = busy_q;
        done_d        = accept && (nblocks == '0);
        if (accept && (nblocks != '0)) begin
            busy_d     = 1'b1;
            out_left_d = nblocks;
        end
        if (busy_q && out_hs) begin
            out_left_d = out_left_q - 32'd1;
        end
        if (finish) begin
            discard_d  = discard_d + inflight_live;
            inflight_d = '0;
            out_left_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            out_left_q  <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            ctr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_left_q  <= out_left_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            ctr_q       <= ctr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            live_q      <= 1'b1;
        end
    end

    assign aes_in_block  = ctr_q;
    assign aes_out_ready = live_q && !fifo_full;
    assign dout_valid    = din_valid && !fifo_empty;
    assign din_ready     = dout_ready && !fifo_empty;
    assign dout_data     = dout_valid ? ((din_data ^ ks_data) & byte_mask(din_bytes)) : '0;
    assign dout_last     = dout_valid && din_last;
    assign dout_bytes    = dout_valid ? din_bytes : '0;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_gctr_xor.sv
// Randomised scoreboard bench for gctr_xor with a counter-generator model and
// an AES stub (keystream = counter XOR A5 pattern, three-cycle latency).
`timescale 1ns/1ps
module tb_gctr_xor;

    localparam int KS_DEPTH = 2;
    localparam logic [127:0] KS_PAD = {16{8'hA5}};

    typedef struct { logic [127:0] data; logic last; logic [4:0] nbytes; } din_t;
    typedef struct { logic [127:0] data; logic last; logic [4:0] nbytes; bit fin; } exp_t;
    typedef struct { logic [127:0] ks; int unsigned due; } aes_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  nblocks = '0;
    logic         ctr_next;
    logic [127:0] ctr_block = '0;
    logic         ctr_valid = 1'b0;
    logic         aes_in_valid;
    logic         aes_in_ready = 1'b0;
    logic [127:0] aes_in_block;
    logic         aes_out_valid = 1'b0;
    logic         aes_out_ready;
    logic [127:0] aes_out_block = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] din_data = '0;
    logic         din_last = 1'b0;
    logic [4:0]   din_bytes = '0;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [127:0] dout_data;
    logic         dout_last;
    logic [4:0]   dout_bytes;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    din_t         din_q[$];
    exp_t         exp_q[$];
    aes_t         aes_q[$];
    logic [127:0] ctr_issued[$];
    logic [95:0]  iv = '0;
    logic [127:0] pend_blk = '0;
    int unsigned  ctr_cnt = 2;
    int unsigned  cyc = 0;
    int unsigned  aes_pct = 100;
    int unsigned  dout_pct = 100;
    int           ctr_next_cnt = 0;
    int           done_cnt = 0;
    bit           ctr_pend = 1'b0;
    bit           busy_seen = 1'b0;
    bit           done_due = 1'b0;

    gctr_xor #(.KS_DEPTH(KS_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .nblocks       (nblocks),
        .ctr_next      (ctr_next),
        .ctr_block     (ctr_block),
        .ctr_valid     (ctr_valid),
        .aes_in_valid  (aes_in_valid),
        .aes_in_ready  (aes_in_ready),
        .aes_in_block  (aes_in_block),
        .aes_out_valid (aes_out_valid),
        .aes_out_ready (aes_out_ready),
        .aes_out_block (aes_out_block),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .din_data      (din_data),
        .din_last      (din_last),
        .din_bytes     (din_bytes),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_data     (dout_data),
        .dout_last     (dout_last),
        .dout_bytes    (dout_bytes),
        .busy          (busy),
        .done          (done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: required event not observed", name);
    endtask

    // Reference: k-th block of a message uses counter IV||(k+2); bytes past nb are zero.
    function automatic logic [127:0] model_out(input logic [95:0] iv_v, input int k,
                                               input logic [127:0] d, input int nb);
        logic [127:0] ks;
        logic [127:0] r;
        ks = {iv_v, 32'(k + 2)} ^ KS_PAD;
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < nb) r[127-8*i -: 8] = d[127-8*i -: 8] ^ ks[127-8*i -: 8];
        end
        return r;
    endfunction

    function automatic logic [10:0] out_vec();
        return {ctr_next, aes_in_valid, |aes_in_block, aes_out_ready, din_ready,
                dout_valid, |dout_data, dout_last, |dout_bytes, busy, done};
    endfunction

    // Environment: counter generator, AES stub and data source, driven on negedge.
    initial begin : env
        din_t d;
        aes_t a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aes_q.delete();
                ctr_pend      = 1'b0;
                ctr_valid     = 1'b0;
                ctr_block     = '0;
                aes_in_ready  = 1'b0;
                aes_out_valid = 1'b0;
                aes_out_block = '0;
                din_valid     = 1'b0;
                din_data      = '0;
                din_last      = 1'b0;
                din_bytes     = '0;
                dout_ready    = 1'b0;
            end else begin
                cyc++;
                ctr_valid     = ctr_pend;
                ctr_block     = ctr_pend ? pend_blk : '0;
                aes_in_ready  = ($urandom_range(99) < aes_pct);
                aes_out_valid = (aes_q.size() != 0) && (aes_q[0].due <= cyc);
                aes_out_block = (aes_q.size() != 0) ? aes_q[0].ks : '0;
                din_valid     = (din_q.size() != 0);
                d             = (din_q.size() != 0) ? din_q[0] : '{default: '0};
                din_data      = d.data;
                din_last      = d.last;
                din_bytes     = d.nbytes;
                dout_ready    = ($urandom_range(99) < dout_pct);
                #1;
                ctr_pend = ctr_next;
                if (ctr_next) begin
                    ctr_next_cnt++;
                    pend_blk = {iv, 32'(ctr_cnt)};
                    ctr_cnt++;
                    ctr_issued.push_back(pend_blk);
                end
                if (aes_in_valid && aes_in_ready) begin
                    if (ctr_issued.size() == 0) begin
                        fail("aes_in_unrequested");
                    end else begin
                        check("aes_in_block", aes_in_block, ctr_issued.pop_front());
                    end
                    a.ks  = aes_in_block ^ KS_PAD;
                    a.due = cyc + 3;
                    aes_q.push_back(a);
                end
                if (aes_out_valid && aes_out_ready) void'(aes_q.pop_front());
                if (din_valid && din_ready) void'(din_q.pop_front());
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                done_due = 1'b0;
            end else begin
                if (done_due) begin
                    check("done_pulse", done, 1);
                    done_due = 1'b0;
                end
                if (done) done_cnt++;
                if (busy) busy_seen = 1'b1;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        check("dout_data", dout_data, e.data);
                        check("dout_last", dout_last, e.last);
                        check("dout_bytes", dout_bytes, e.nbytes);
                        if (e.fin) done_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] n);
        nblocks = n;
        start   = 1'b1;
        @(negedge clk);
        #3;
        start   = 1'b0;
    endtask

    task automatic start_msg(input logic [31:0] n, input int nin, input int last_bytes,
                             input bit set_last, input bit zero_data);
        din_t d;
        exp_t e;
        din_q.delete();
        exp_q.delete();
        ctr_issued.delete();
        ctr_cnt      = 2;
        ctr_next_cnt = 0;
        done_cnt     = 0;
        for (int k = 0; k < nin; k++) begin
            d.data   = zero_data ? '0 : {$urandom, $urandom, $urandom, $urandom};
            d.last   = set_last && (k == nin - 1);
            d.nbytes = (k == nin - 1) ? 5'(last_bytes) : 5'd16;
            e.data   = model_out(iv, k, d.data, int'(d.nbytes));
            e.last   = d.last;
            e.nbytes = d.nbytes;
            e.fin    = (k == nin - 1);
            din_q.push_back(d);
            exp_q.push_back(e);
        end
        pulse_start(n);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy || done_due) && c < budget) begin
            @(negedge clk);
            #3;
            c++;
        end
        if (exp_q.size() != 0 || busy || done_due) fail("msg_timeout");
        repeat (2) begin
            @(negedge clk);
            #3;
        end
        check("done_count", done_cnt, 1);
    endtask

    task automatic wait_aes_drain();
        int c;
        c = 0;
        while (aes_q.size() != 0 && c < 30) begin
            @(negedge clk);
            #3;
            c++;
        end
        check("stale_keystream_drained", aes_q.size(), 0);
        repeat (3) @(negedge clk);
        #3;
    endtask

    initial begin : stim
        logic spur;
        int   c;
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        logic spur;
        int   c;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", out_vec(), '0);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #3;

        // Single all-zero block with the fixed IV.
        iv = 96'hCAFEBABEFACEDBADDECAF888;
        start_msg(1, 1, 16, 1'b1, 1'b1);
        exp_q[0].data = 128'h6F5B1F1B5F6B7E08_7B6F5D2DA5A5A5A7;
        wait_done(200);

        // Output stalled: fetch must stop once the buffer and AES are full.
        iv = {$urandom, $urandom, $urandom};
        dout_pct = 0;
        start_msg(4, 4, 16, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        #3;
        check("ctr_next_under_backpressure", ctr_next_cnt, KS_DEPTH);
        dout_pct = 100;
        wait_done(300);
        check("ctr_next_total_4", ctr_next_cnt, 4);

        // Partial final block.
        iv = {$urandom, $urandom, $urandom};
        start_msg(3, 3, 5, 1'b1, 1'b0);
        wait_done(300);

        // Empty message.
        ctr_next_cnt = 0;
        done_cnt     = 0;
        busy_seen    = 1'b0;
        pulse_start(0);
        check("zero_len_done", done, 1);
        repeat (5) @(negedge clk);
        #3;
        check("zero_len_done_count", done_cnt, 1);
        check("zero_len_busy_never", busy_seen, 0);
        check("zero_len_no_ctr_next", ctr_next_cnt, 0);

        // Early din_last on a maximal block count, then a clean follow-up message.
        iv = {$urandom, $urandom, $urandom};
        dout_pct = 50;
        start_msg(32'hFFFF_FFFF, 3, 16, 1'b1, 1'b0);
        wait_done(400);
        wait_aes_drain();
        iv = {$urandom, $urandom, $urandom};
        start_msg(5, 5, 9, 1'b1, 1'b0);
        wait_done(400);
        dout_pct = 100;

        // Reset while ISSUE is stalled.
        iv = {$urandom, $urandom, $urandom};
        aes_pct = 0;
        start_msg(3, 3, 16, 1'b1, 1'b0);
        c = 0;
        while (!aes_in_valid && c < 20) begin
            @(negedge clk);
            #3;
            c++;
        end
        check("issue_reached", aes_in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_in_issue_outputs", out_vec(), '0);
        din_q.delete();
        exp_q.delete();
        ctr_issued.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        aes_pct = 100;
        spur = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #3;
            spur = spur | ctr_next | aes_in_valid | done;
        end
        check("no_activity_after_reset", spur, 0);
        iv = {$urandom, $urandom, $urandom};
        start_msg(2, 2, 16, 1'b1, 1'b0);
        wait_done(300);

        // Long randomised message ended by the block count (no din_last).
        iv = {$urandom, $urandom, $urandom};
        aes_pct  = 50;
        dout_pct = 50;
        start_msg(64, 64, 16, 1'b0, 1'b0);
        wait_done(6000);
        check("ctr_next_total_64", ctr_next_cnt, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
